msi_bus_controller: RTL and testbench

Two-core snooping-bus sequencer for the MSI cache pair: arbitrates coherence requests from the two `cache_directlyMapped_32x21bits` instances, broadcasts the winner's request to the other cache, serialises write-backs to main memory, then returns fill data from memory or from the snooping cache. Sits between both caches and the single-ported main memory. It replaces the free-running bus wiring: only one bus transaction is in flight at a time.

---
 rtl/msi_bus_pkg.sv | 33 +++
 rtl/msi_bus_if.sv | 46 ++++
 rtl/msi_bus_controller_rr_arbiter2.sv | 21 ++
 rtl/msi_bus_controller.sv | 174 +++++++++++++++++
 tb/tb_msi_bus_controller.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/msi_bus_pkg.sv
// Shared types for the MSI snooping-bus controller.
// Bus command codes, FSM states and default widths.
package msi_bus_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    BUS_INVALIDATE = 2'b00,
    BUS_WRITE_MISS = 2'b01,
    BUS_READ_MISS  = 2'b10,
    BUS_NONE       = 2'b11
  } bus_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VICTIM_WB,
    ST_SNOOP,
    ST_SNOOP_WB,
    ST_MEM_RD,
    ST_DONE
  } state_e;

  // Place the command in the slot of the core that did not win the bus.
  function automatic logic [3:0] snoop_vec(
    input logic     g,
    input bus_cmd_e c
  );
    if (g) return {BUS_NONE, c};
    else   return {c, BUS_NONE};
  endfunction

endpackage

// File: rtl/msi_bus_if.sv
// Bundle of cache, snoop and memory signals around the bus controller.
// master = controller side, slave = caches/memory side.
interface msi_bus_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic [3:0]          req_cmd;
  logic [2*ADDR_W-1:0] req_addr;
  logic [1:0]          victim_wb;
  logic [2*ADDR_W-1:0] victim_addr;
  logic [2*DATA_W-1:0] victim_data;
  logic [3:0]          snoop_cmd;
  logic [ADDR_W-1:0]   snoop_addr;
  logic [1:0]          snoop_found;
  logic [1:0]          snoop_wb;
  logic [2*DATA_W-1:0] snoop_data;
  logic                mem_rd;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ready;
  logic [1:0]          done;
  logic [DATA_W-1:0]   fill_data;
  logic                fill_from_cache;

  modport master (
    input  req_cmd, req_addr, victim_wb,
    input  victim_addr, victim_data,
    input  snoop_found, snoop_wb, snoop_data,
    input  mem_rdata, mem_ready,
    output snoop_cmd, snoop_addr,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output done, fill_data, fill_from_cache
  );

  modport slave (
    output req_cmd, req_addr, victim_wb,
    output victim_addr, victim_data,
    output snoop_found, snoop_wb, snoop_data,
    output mem_rdata, mem_ready,
    input  snoop_cmd, snoop_addr,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  done, fill_data, fill_from_cache
  );
endinterface

// File: rtl/msi_bus_controller_rr_arbiter2.sv
// Two-requester round-robin arbiter.
// A tie goes to the core that did not win last time.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_any
);

  // Pick the winner from the request pair and the previous grant.
  always_comb begin
    o_any   = |i_req;
    o_grant = 1'b0;
    unique case (i_req)
      2'b11:   o_grant = ~i_last_grant;
      2'b10:   o_grant = 1'b1;
      default: o_grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/msi_bus_controller.sv
// Snooping-bus sequencer for a two-core MSI cache pair.
// One transaction at a time: victim WB, snoop, snoop WB / mem read, done.
module msi_bus_controller
  import msi_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic       clk,
  input logic       reset,
  msi_bus_if.master bus
);

  state_e              r_state;
  logic                r_g;
  bus_cmd_e            r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_last;
  logic [3:0]          r_snoop_cmd;
  logic [ADDR_W-1:0]   r_snoop_addr;
  logic                r_mem_rd;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [1:0]          r_done;
  logic [DATA_W-1:0]   r_fill;
  logic                r_fill_fc;

  logic [1:0]          w_req;
  logic                w_grant;
  logic                w_any;
  bus_cmd_e            w_cmd;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_vwb;
  logic [ADDR_W-1:0]   w_vaddr;
  logic [DATA_W-1:0]   w_vdata;
  logic                w_sfound;
  logic                w_swb;
  logic [DATA_W-1:0]   w_sdata;
  logic [1:0]          w_done_vec;

  assign w_req[0] = bus.req_cmd[1:0] != BUS_NONE;
  assign w_req[1] = bus.req_cmd[3:2] != BUS_NONE;

  rr_arbiter2 u_arb (
    .i_req        (w_req),
    .i_last_grant (r_last),
    .o_grant      (w_grant),
    .o_any        (w_any)
  );

  assign w_cmd = bus_cmd_e'(w_grant ? bus.req_cmd[3:2]
                                    : bus.req_cmd[1:0]);
  assign w_addr = w_grant ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                          : bus.req_addr[ADDR_W-1:0];
  assign w_vwb = w_grant ? bus.victim_wb[1] : bus.victim_wb[0];
  assign w_vaddr = w_grant ? bus.victim_addr[2*ADDR_W-1:ADDR_W]
                           : bus.victim_addr[ADDR_W-1:0];
  assign w_vdata = w_grant ? bus.victim_data[2*DATA_W-1:DATA_W]
                           : bus.victim_data[DATA_W-1:0];

  // Snoop responses come from the core that is not granted.
  assign w_sfound = r_g ? bus.snoop_found[0] : bus.snoop_found[1];
  assign w_swb    = r_g ? bus.snoop_wb[0] : bus.snoop_wb[1];
  assign w_sdata  = r_g ? bus.snoop_data[DATA_W-1:0]
                        : bus.snoop_data[2*DATA_W-1:DATA_W];
  assign w_done_vec = {r_g, ~r_g};

  // Transaction sequencer with registered bus and memory outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_g          <= 1'b0;
      r_cmd        <= BUS_NONE;
      r_addr       <= '0;
      r_last       <= 1'b1;
      r_snoop_cmd  <= 4'b1111;
      r_snoop_addr <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_done       <= 2'b00;
      r_fill       <= '0;
      r_fill_fc    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_g    <= w_grant;
            r_cmd  <= w_cmd;
            r_addr <= w_addr;
            if (w_vwb) begin
              r_state     <= ST_VICTIM_WB;
              r_mem_wr    <= 1'b1;
              r_mem_addr  <= w_vaddr;
              r_mem_wdata <= w_vdata;
            end else begin
              r_state      <= ST_SNOOP;
              r_snoop_cmd  <= snoop_vec(w_grant, w_cmd);
              r_snoop_addr <= w_addr;
            end
          end
        end
        ST_VICTIM_WB: begin
          if (bus.mem_ready) begin
            r_mem_wr     <= 1'b0;
            r_state      <= ST_SNOOP;
            r_snoop_cmd  <= snoop_vec(r_g, r_cmd);
            r_snoop_addr <= r_addr;
          end
        end
        ST_SNOOP: begin
          r_snoop_cmd <= 4'b1111;
          if (r_cmd == BUS_INVALIDATE) begin
            r_state   <= ST_DONE;
            r_done    <= w_done_vec;
            r_fill    <= '0;
            r_fill_fc <= 1'b0;
          end else if (w_swb) begin
            r_state     <= ST_SNOOP_WB;
            r_mem_wr    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= w_sdata;
          end else if (w_sfound) begin
            r_state   <= ST_DONE;
            r_done    <= w_done_vec;
            r_fill    <= w_sdata;
            r_fill_fc <= 1'b1;
          end else begin
            r_state    <= ST_MEM_RD;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= r_addr;
          end
        end
        ST_SNOOP_WB: begin
          if (bus.mem_ready) begin
            r_mem_wr  <= 1'b0;
            r_state   <= ST_DONE;
            r_done    <= w_done_vec;
            r_fill    <= r_mem_wdata;
            r_fill_fc <= 1'b1;
          end
        end
        ST_MEM_RD: begin
          if (bus.mem_ready) begin
            r_mem_rd  <= 1'b0;
            r_state   <= ST_DONE;
            r_done    <= w_done_vec;
            r_fill    <= bus.mem_rdata;
            r_fill_fc <= 1'b0;
          end
        end
        ST_DONE: begin
          r_done  <= 2'b00;
          r_last  <= r_g;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.snoop_cmd       = r_snoop_cmd;
  assign bus.snoop_addr      = r_snoop_addr;
  assign bus.mem_rd          = r_mem_rd;
  assign bus.mem_wr          = r_mem_wr;
  assign bus.mem_addr        = r_mem_addr;
  assign bus.mem_wdata       = r_mem_wdata;
  assign bus.done            = r_done;
  assign bus.fill_data       = r_fill;
  assign bus.fill_from_cache = r_fill_fc;

endmodule

// File: tb/tb_msi_bus_controller.sv
// Directed bench for msi_bus_controller.
// Inputs driven and outputs checked on the falling edge.
module tb_msi_bus_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  msi_bus_if #(.ADDR_W(9), .DATA_W(16)) bus ();

  msi_bus_controller #(.ADDR_W(9), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.req_cmd     = 4'b1111;
    bus.req_addr    = '0;
    bus.victim_wb   = 2'b00;
    bus.victim_addr = '0;
    bus.victim_data = '0;
    bus.snoop_found = 2'b00;
    bus.snoop_wb    = 2'b00;
    bus.snoop_data  = '0;
    bus.mem_rdata   = '0;
    bus.mem_ready   = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_snoop_cmd", 32'(bus.snoop_cmd), 32'hF);
    chk("rst_snoop_addr", 32'(bus.snoop_addr), 32'h0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_fill", 32'(bus.fill_data), 32'h0);
    chk("rst_fc", 32'(bus.fill_from_cache), 32'h0);
    reset = 1'b0;

    // Core 0 read miss served by memory
    bus.req_cmd   = 4'b1110;
    bus.req_addr  = {9'h000, 9'h025};
    bus.mem_rdata = 16'hBEEF;
    tick();
    chk("rm_snoop_cmd", 32'(bus.snoop_cmd), 32'hB);
    chk("rm_snoop_addr", 32'(bus.snoop_addr), 32'h025);
    chk("rm_c1_rd", 32'(bus.mem_rd), 32'h0);
    tick();
    chk("rm_c2_rd", 32'(bus.mem_rd), 32'h1);
    chk("rm_c2_wr", 32'(bus.mem_wr), 32'h0);
    chk("rm_c2_addr", 32'(bus.mem_addr), 32'h025);
    chk("rm_c2_done", 32'(bus.done), 32'h0);
    chk("rm_c2_idle_snoop", 32'(bus.snoop_cmd), 32'hF);
    tick();
    chk("rm_done", 32'(bus.done), 32'h1);
    chk("rm_fill", 32'(bus.fill_data), 32'hBEEF);
    chk("rm_fc", 32'(bus.fill_from_cache), 32'h0);
    chk("rm_c3_rd", 32'(bus.mem_rd), 32'h0);
    bus.req_cmd = 4'b1111;
    tick();
    chk("rm_done_pulse", 32'(bus.done), 32'h0);

    // Core 1 read miss, core 0 holds it modified
    bus.req_cmd     = 4'b1011;
    bus.req_addr    = {9'h025, 9'h000};
    bus.snoop_found = 2'b01;
    bus.snoop_wb    = 2'b01;
    bus.snoop_data  = {16'h0000, 16'h1234};
    bus.mem_rdata   = 16'hDEAD;
    tick();
    chk("sw_snoop_cmd", 32'(bus.snoop_cmd), 32'hE);
    chk("sw_snoop_addr", 32'(bus.snoop_addr), 32'h025);
    tick();
    chk("sw_wr", 32'(bus.mem_wr), 32'h1);
    chk("sw_rd", 32'(bus.mem_rd), 32'h0);
    chk("sw_addr", 32'(bus.mem_addr), 32'h025);
    chk("sw_wdata", 32'(bus.mem_wdata), 32'h1234);
    tick();
    chk("sw_done", 32'(bus.done), 32'h2);
    chk("sw_fill", 32'(bus.fill_data), 32'h1234);
    chk("sw_fc", 32'(bus.fill_from_cache), 32'h1);
    chk("sw_c3_rd", 32'(bus.mem_rd), 32'h0);
    chk("sw_c3_wr", 32'(bus.mem_wr), 32'h0);
    bus.req_cmd     = 4'b1111;
    bus.snoop_found = 2'b00;
    bus.snoop_wb    = 2'b00;
    bus.snoop_data  = '0;
    tick();

    // Tie after reset: core 0 first, then core 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_cmd   = 4'b1010;
    bus.req_addr  = {9'h022, 9'h011};
    bus.mem_rdata = 16'h1111;
    tick();
    chk("tie1_snoop_addr", 32'(bus.snoop_addr), 32'h011);
    chk("tie1_snoop_cmd", 32'(bus.snoop_cmd), 32'hB);
    repeat (2) tick();
    chk("tie1_done", 32'(bus.done), 32'h1);
    chk("tie1_fill", 32'(bus.fill_data), 32'h1111);
    bus.req_cmd   = 4'b1011;
    bus.mem_rdata = 16'h2222;
    tick();
    chk("tie_idle_gap", 32'(bus.done), 32'h0);
    chk("tie_idle_snoop", 32'(bus.snoop_cmd), 32'hF);
    tick();
    chk("tie2_snoop_addr", 32'(bus.snoop_addr), 32'h022);
    chk("tie2_snoop_cmd", 32'(bus.snoop_cmd), 32'hE);
    repeat (2) tick();
    chk("tie2_done", 32'(bus.done), 32'h2);
    chk("tie2_fill", 32'(bus.fill_data), 32'h2222);
    bus.req_cmd = 4'b1111;
    tick();

    // Core 0 write miss with victim write-back, two wait states
    bus.req_cmd     = 4'b1101;
    bus.req_addr    = {9'h000, 9'h1A3};
    bus.victim_wb   = 2'b01;
    bus.victim_addr = {9'h000, 9'h0A3};
    bus.victim_data = {16'h0000, 16'h00FF};
    bus.mem_ready   = 1'b0;
    bus.mem_rdata   = 16'hCAFE;
    tick();
    chk("vw_c1_wr", 32'(bus.mem_wr), 32'h1);
    chk("vw_c1_rd", 32'(bus.mem_rd), 32'h0);
    chk("vw_c1_addr", 32'(bus.mem_addr), 32'h0A3);
    chk("vw_c1_wdata", 32'(bus.mem_wdata), 32'h00FF);
    chk("vw_c1_snoop", 32'(bus.snoop_cmd), 32'hF);
    tick();
    chk("vw_c2_wr", 32'(bus.mem_wr), 32'h1);
    chk("vw_c2_snoop", 32'(bus.snoop_cmd), 32'hF);
    tick();
    chk("vw_c3_wr", 32'(bus.mem_wr), 32'h1);
    bus.mem_ready = 1'b1;
    tick();
    chk("vw_c4_wr", 32'(bus.mem_wr), 32'h0);
    chk("vw_c4_rd", 32'(bus.mem_rd), 32'h0);
    chk("vw_c4_snoop_cmd", 32'(bus.snoop_cmd), 32'h7);
    chk("vw_c4_snoop_addr", 32'(bus.snoop_addr), 32'h1A3);
    tick();
    chk("vw_c5_rd", 32'(bus.mem_rd), 32'h1);
    chk("vw_c5_wr", 32'(bus.mem_wr), 32'h0);
    chk("vw_c5_addr", 32'(bus.mem_addr), 32'h1A3);
    tick();
    chk("vw_done", 32'(bus.done), 32'h1);
    chk("vw_fill", 32'(bus.fill_data), 32'hCAFE);
    chk("vw_fc", 32'(bus.fill_from_cache), 32'h0);
    bus.req_cmd     = 4'b1111;
    bus.victim_wb   = 2'b00;
    bus.victim_addr = '0;
    bus.victim_data = '0;
    tick();

    // Core 1 invalidate
    bus.req_cmd  = 4'b0011;
    bus.req_addr = {9'h007, 9'h000};
    tick();
    chk("inv_snoop_cmd", 32'(bus.snoop_cmd), 32'hC);
    chk("inv_snoop_addr", 32'(bus.snoop_addr), 32'h007);
    chk("inv_c1_strobes", 32'({bus.mem_rd, bus.mem_wr}), 32'h0);
    tick();
    chk("inv_done", 32'(bus.done), 32'h2);
    chk("inv_c2_strobes", 32'({bus.mem_rd, bus.mem_wr}), 32'h0);
    chk("inv_c2_snoop", 32'(bus.snoop_cmd), 32'hF);
    chk("inv_fc", 32'(bus.fill_from_cache), 32'h0);
    bus.req_cmd = 4'b1111;
    tick();

    // Reset in the middle of a memory read
    bus.req_cmd   = 4'b1110;
    bus.req_addr  = {9'h000, 9'h055};
    bus.mem_rdata = 16'h5555;
    repeat (2) tick();
    chk("mr_rd_before", 32'(bus.mem_rd), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_rd_async", 32'(bus.mem_rd), 32'h0);
    chk("mr_done_async", 32'(bus.done), 32'h0);
    chk("mr_addr_async", 32'(bus.mem_addr), 32'h0);
    bus.req_cmd = 4'b1111;
    tick();
    reset = 1'b0;
    tick();
    chk("mr_no_done", 32'(bus.done), 32'h0);
    bus.req_cmd  = 4'b1010;
    bus.req_addr = {9'h077, 9'h066};
    bus.mem_rdata = 16'h6666;
    tick();
    chk("mr_tie_addr", 32'(bus.snoop_addr), 32'h066);
    repeat (2) tick();
    chk("mr_tie_done", 32'(bus.done), 32'h1);
    chk("mr_tie_fill", 32'(bus.fill_data), 32'h6666);
    bus.req_cmd = 4'b1111;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
